// File: rtl/hydra_switch.sv
// hydra_switch: 16-port store-and-forward packet switch, 64-word FIFO per input,
// whole-packet transfers to each output with selectable arbitration.
module hydra_switch (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       wr_sop,
    input  logic [15:0]       wr_eop,
    input  logic [15:0]       wr_vld,
    input  logic [15:0][15:0] wr_data,
    output logic [15:0]       pause,
    input  logic [15:0]       ready,
    output logic [15:0]       rd_sop,
    output logic [15:0]       rd_eop,
    output logic [15:0]       rd_vld,
    output logic [15:0][15:0] rd_data,
    input  logic [15:0]       wrr_enable,
    input  logic [4:0]        match_threshold,
    input  logic [1:0]        match_mode
);
    typedef enum logic {IN_IDLE, IN_OPEN} in_state_t;
    typedef enum logic [1:0] {OUT_IDLE, OUT_SOP, OUT_DATA, OUT_EOP} out_state_t;

    in_state_t  [15:0] in_state, in_next;
    out_state_t [15:0] out_state, out_next;

    logic [15:0][6:0]  wr_ptr, rd_ptr, start_ptr, pkt_cnt, used, free_w;
    logic [15:0][63:0] last_mark;
    logic [15:0][15:0] head_word;
    logic [15:0][3:0]  src, rr_ptr, gnt_idx;
    logic [15:0]       ovf, full, wr_en, commit, rollback, mark_prev;
    logic [15:0]       busy, rd_adv, cnt_dec, gnt_vld;

    // Per-input packet storage; the head word doubles as the output read port.
    for (genvar g = 0; g < 16; g++) begin : g_fifo
        logic [15:0] mem [64];
        always_ff @(posedge clk) begin
            if (wr_en[g]) begin
                mem[wr_ptr[g][5:0]] <= wr_data[g];
            end
        end
        assign head_word[g] = mem[rd_ptr[g][5:0]];
    end

    always_comb begin
        for (int unsigned i = 0; i < 16; i++) begin
            used[i]      = wr_ptr[i] - rd_ptr[i];
            free_w[i]    = 7'd64 - used[i];
            full[i]      = used[i][6];
            in_next[i]   = in_state[i];
            wr_en[i]     = 1'b0;
            commit[i]    = 1'b0;
            rollback[i]  = 1'b0;
            mark_prev[i] = 1'b0;
            if (in_state[i] == IN_IDLE) begin
                if (wr_sop[i]) in_next[i] = IN_OPEN;
            end else begin
                wr_en[i] = wr_vld[i] && !full[i];
                if (wr_eop[i]) begin
                    in_next[i] = IN_IDLE;
                    if (ovf[i] || (wr_vld[i] && full[i])) begin
                        rollback[i] = 1'b1;
                    end else if (wr_en[i]) begin
                        commit[i] = 1'b1;
                    end else if (wr_ptr[i] != start_ptr[i]) begin
                        // close without data: the last word was written earlier
                        commit[i]    = 1'b1;
                        mark_prev[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_state  <= {16{IN_IDLE}};
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            start_ptr <= '0;
            pkt_cnt   <= '0;
            ovf       <= '0;
            pause     <= '0;
        end else begin
            for (int unsigned i = 0; i < 16; i++) begin
                in_state[i] <= in_next[i];
                pause[i]    <= (free_w[i] <= {2'b00, match_threshold});
                if (in_state[i] == IN_IDLE && wr_sop[i]) begin
                    start_ptr[i] <= wr_ptr[i];
                    ovf[i]       <= 1'b0;
                end else if (in_state[i] == IN_OPEN && wr_vld[i] && full[i]) begin
                    ovf[i] <= 1'b1;
                end
                if (rollback[i]) begin
                    wr_ptr[i] <= start_ptr[i];
                end else if (wr_en[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + 7'd1;
                end
                if (rd_adv[i]) rd_ptr[i] <= rd_ptr[i] + 7'd1;
                pkt_cnt[i] <= pkt_cnt[i] + {6'b0, commit[i]} - {6'b0, cnt_dec[i]};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 16; i++) begin
            if (wr_en[i]) begin
                last_mark[i][wr_ptr[i][5:0]] <= wr_eop[i];
            end else if (mark_prev[i]) begin
                last_mark[i][wr_ptr[i][5:0] - 6'd1] <= 1'b1;
            end
        end
    end

    always_comb begin
        busy    = '0;
        rd_adv  = '0;
        cnt_dec = '0;
        for (int unsigned o = 0; o < 16; o++) begin
            if (out_state[o] != OUT_IDLE) busy[src[o]] = 1'b1;
            if (out_state[o] == OUT_DATA) rd_adv[src[o]] = 1'b1;
            if (out_state[o] == OUT_EOP)  cnt_dec[src[o]] = 1'b1;
        end
    end

    always_comb begin
        logic [15:0] cand;
        logic [2:0]  best;
        logic [3:0]  idx;
        for (int unsigned o = 0; o < 16; o++) begin
            cand       = '0;
            best       = '0;
            idx        = '0;
            gnt_vld[o] = 1'b0;
            gnt_idx[o] = '0;
            for (int unsigned i = 0; i < 16; i++) begin
                cand[i] = (pkt_cnt[i] != 7'd0) && wrr_enable[i] && !busy[i] &&
                          (head_word[i][3:0] == 4'(o));
            end
            if (match_mode == 2'd2) begin
                for (int unsigned i = 0; i < 16; i++) begin
                    if (cand[i] && head_word[i][6:4] > best) best = head_word[i][6:4];
                end
                for (int unsigned i = 0; i < 16; i++) begin
                    if (cand[i] && head_word[i][6:4] != best) cand[i] = 1'b0;
                end
            end
            // descending scans so the first hit in priority order is the last assignment
            if (match_mode == 2'd0) begin
                for (int unsigned i = 16; i > 0; i--) begin
                    if (cand[i-1]) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = 4'(i - 1);
                    end
                end
            end else begin
                for (int unsigned k = 16; k > 0; k--) begin
                    idx = rr_ptr[o] + 4'(k - 1);
                    if (cand[idx]) begin
                        gnt_vld[o] = 1'b1;
                        gnt_idx[o] = idx;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int unsigned o = 0; o < 16; o++) begin
            out_next[o] = out_state[o];
            rd_sop[o]   = 1'b0;
            rd_eop[o]   = 1'b0;
            rd_vld[o]   = 1'b0;
            rd_data[o]  = '0;
            case (out_state[o])
                OUT_IDLE: if (ready[o] && gnt_vld[o]) out_next[o] = OUT_SOP;
                OUT_SOP: begin
                    rd_sop[o]   = 1'b1;
                    out_next[o] = OUT_DATA;
                end
                OUT_DATA: begin
                    rd_vld[o]  = 1'b1;
                    rd_data[o] = head_word[src[o]];
                    if (last_mark[src[o]][rd_ptr[src[o]][5:0]]) out_next[o] = OUT_EOP;
                end
                OUT_EOP: begin
                    rd_eop[o]   = 1'b1;
                    out_next[o] = (ready[o] && gnt_vld[o]) ? OUT_SOP : OUT_IDLE;
                end
                default: out_next[o] = OUT_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_state <= {16{OUT_IDLE}};
            src       <= '0;
            rr_ptr    <= '0;
        end else begin
            for (int unsigned o = 0; o < 16; o++) begin
                out_state[o] <= out_next[o];
                if (out_next[o] == OUT_SOP) begin
                    src[o]    <= gnt_idx[o];
                    rr_ptr[o] <= gnt_idx[o] + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hydra_switch.sv
// Scoreboard bench for hydra_switch: directed packets, expected words queued per
// transfer, a negedge monitor pops and compares every delivered word.
module tb_hydra_switch;
    logic              clk = 1'b0;
    logic              rst_n;
    logic [15:0]       wr_sop, wr_eop, wr_vld, pause, ready;
    logic [15:0]       rd_sop, rd_eop, rd_vld, wrr_enable;
    logic [15:0][15:0] wr_data, rd_data;
    logic [4:0]        match_threshold;
    logic [1:0]        match_mode;

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];
    int sop_cnt[16];
    int eop_cnt[16];

    hydra_switch dut (
        .clk(clk), .rst_n(rst_n), .wr_sop(wr_sop), .wr_eop(wr_eop), .wr_vld(wr_vld),
        .wr_data(wr_data), .pause(pause), .ready(ready), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .rd_vld(rd_vld), .rd_data(rd_data), .wrr_enable(wrr_enable),
        .match_threshold(match_threshold), .match_mode(match_mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int o = 0; o < 16; o++) begin
            if (rd_sop[o]) sop_cnt[o]++;
            if (rd_eop[o]) eop_cnt[o]++;
            if (rd_vld[o]) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word out=%0d got=%h want=none", o, rd_data[o]);
                end else begin
                    chk("rd_word", {44'b0, 4'(o), rd_data[o]}, {44'b0, exp_q.pop_front()});
                end
            end else begin
                chk("rd_data_idle_zero", {48'b0, rd_data[o]}, 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wr_sop = '0;
        wr_eop = '0;
        wr_vld = '0;
        wr_data = '0;
        step();
        chk("rst_outputs", {pause, rd_sop, rd_eop, rd_vld}, 64'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        for (int o = 0; o < 16; o++) begin
            sop_cnt[o] = 0;
            eop_cnt[o] = 0;
        end
    endtask

    // Header, then ndata words {tag, k}; wr_eop rides on the last word.
    task automatic send_pkt(input int port, input logic [15:0] hdr, input int ndata,
                            input logic [7:0] tag);
        wr_sop[port] = 1'b1;
        step();
        wr_sop[port] = 1'b0;
        for (int k = 0; k <= ndata; k++) begin
            wr_vld[port]  = 1'b1;
            wr_data[port] = (k == 0) ? hdr : {tag, 8'(k)};
            wr_eop[port]  = (k == ndata);
            step();
        end
        wr_vld[port]  = 1'b0;
        wr_eop[port]  = 1'b0;
        wr_data[port] = '0;
    endtask

    task automatic push_pkt(input int dest, input logic [15:0] hdr, input int ndata,
                            input logic [7:0] tag);
        exp_q.push_back({4'(dest), hdr});
        for (int k = 1; k <= ndata; k++) exp_q.push_back({4'(dest), tag, 8'(k)});
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while (exp_q.size() != 0 && c < max_cycles) begin
            step();
            c++;
        end
        repeat (4) step();
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_frames(input int o, input int n);
        int all_sop = 0;
        for (int j = 0; j < 16; j++) all_sop += sop_cnt[j];
        chk("sop_count", 64'(sop_cnt[o]), 64'(n));
        chk("eop_count", 64'(eop_cnt[o]), 64'(n));
        chk("sop_all_outputs", 64'(all_sop), 64'(n));
    endtask

    logic [15:0] h0, h1, h2;
    logic        seen;

    initial begin
        ready = '0;
        wrr_enable = '1;
        match_threshold = 5'd0;
        match_mode = 2'd0;
        do_reset();

        // single packet, lowest-index mode
        h0 = {9'd31, 3'd4, 4'd3};
        send_pkt(0, h0, 32, 8'h10);
        push_pkt(3, h0, 32, 8'h10);
        ready[3] = 1'b1;
        @(posedge clk);
        #1 ready[3] = 1'b0;
        @(negedge clk);
        chk("sop_latency", {63'b0, rd_sop[3]}, 64'd1);
        wait_drain(100);
        check_frames(3, 1);

        // priority contention: input 2 first, then round-robin 0, 1
        do_reset();
        match_mode = 2'd2;
        h0 = {9'd0, 3'd4, 4'd3};
        h1 = {9'd1, 3'd4, 4'd3};
        h2 = {9'd2, 3'd5, 4'd3};
        send_pkt(0, h0, 4, 8'h20);
        send_pkt(1, h1, 4, 8'h21);
        send_pkt(2, h2, 4, 8'h22);
        push_pkt(3, h2, 4, 8'h22);
        push_pkt(3, h0, 4, 8'h20);
        push_pkt(3, h1, 4, 8'h21);
        ready[3] = 1'b1;
        wait_drain(100);
        ready[3] = 1'b0;
        check_frames(3, 3);

        // round-robin between two inputs with two packets each
        do_reset();
        match_mode = 2'd1;
        send_pkt(0, {9'd10, 3'd1, 4'd5}, 3, 8'h30);
        send_pkt(0, {9'd11, 3'd1, 4'd5}, 2, 8'h31);
        send_pkt(1, {9'd12, 3'd1, 4'd5}, 3, 8'h32);
        send_pkt(1, {9'd13, 3'd1, 4'd5}, 1, 8'h33);
        push_pkt(5, {9'd10, 3'd1, 4'd5}, 3, 8'h30);
        push_pkt(5, {9'd12, 3'd1, 4'd5}, 3, 8'h32);
        push_pkt(5, {9'd11, 3'd1, 4'd5}, 2, 8'h31);
        push_pkt(5, {9'd13, 3'd1, 4'd5}, 1, 8'h33);
        ready[5] = 1'b1;
        wait_drain(100);
        ready[5] = 1'b0;
        check_frames(5, 4);

        // backpressure at the threshold boundary, then an overflowing packet
        do_reset();
        match_mode = 2'd0;
        match_threshold = 5'd20;
        chk("pause_empty", {63'b0, pause[4]}, 64'd0);
        send_pkt(4, {9'd43, 3'd0, 4'd6}, 43, 8'h40);
        chk("pause_free21", {63'b0, pause[4]}, 64'd0);
        step();
        chk("pause_free20", {63'b0, pause[4]}, 64'd1);
        send_pkt(4, {9'd29, 3'd0, 4'd6}, 29, 8'h41);
        step();
        chk("pause_after_drop", {63'b0, pause[4]}, 64'd1);
        push_pkt(6, {9'd43, 3'd0, 4'd6}, 43, 8'h40);
        ready[6] = 1'b1;
        wait_drain(200);
        repeat (20) step();
        ready[6] = 1'b0;
        check_frames(6, 1);
        chk("pause_released", {63'b0, pause[4]}, 64'd0);
        match_threshold = 5'd0;

        // eligibility masking
        do_reset();
        wrr_enable[0] = 1'b0;
        send_pkt(0, {9'd5, 3'd2, 4'd1}, 5, 8'h50);
        ready[1] = 1'b1;
        repeat (10) step();
        chk("masked_no_sop", 64'(sop_cnt[1]), 64'd0);
        push_pkt(1, {9'd5, 3'd2, 4'd1}, 5, 8'h50);
        wrr_enable[0] = 1'b1;
        @(negedge clk);
        chk("enable_sop_early", {63'b0, rd_sop[1]}, 64'd0);
        @(negedge clk);
        chk("enable_sop", {63'b0, rd_sop[1]}, 64'd1);
        wait_drain(100);
        ready[1] = 1'b0;
        check_frames(1, 1);

        // reset during DATA
        do_reset();
        send_pkt(0, {9'd7, 3'd3, 4'd2}, 20, 8'h60);
        push_pkt(2, {9'd7, 3'd3, 4'd2}, 20, 8'h60);
        ready[2] = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            step();
            seen = rd_vld[2];
        end
        chk("vld_before_reset", {63'b0, seen}, 64'd1);
        repeat (3) step();
        do_reset();
        repeat (40) step();
        ready[2] = 1'b0;
        chk("no_residual_sop", 64'(sop_cnt[2]), 64'd0);
        chk("no_residual_vld", {48'b0, rd_vld}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
